// File: rtl/rr_lock_arbiter.sv
// rr_lock_arbiter: round-robin arbiter that locks the grant to one owner
// until done_i, a request drop, or a MAX_HOLD-cycle tenure limit.
//
// Ports:
//   clk_i       - clock, all state updates on rising edge
//   rst_ni      - asynchronous active-low reset
//   req_i       - level request per port, held until served
//   done_i      - owner release pulse, ignored when no grant is active
//   gnt_o       - registered one-hot grant (or zero)
//   gnt_valid_o - high exactly when gnt_o is non-zero
//   gnt_id_o    - binary index of the granted port, 0 when idle
//   timeout_o   - one-cycle pulse when the tenure limit revokes a grant
module rr_lock_arbiter #(
    parameter int NUM_PORTS = 5,
    parameter int MAX_HOLD  = 16,
    localparam int ID_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic                 done_i,
    output logic [NUM_PORTS-1:0] gnt_o,
    output logic                 gnt_valid_o,
    output logic [ID_W-1:0]      gnt_id_o,
    output logic                 timeout_o
);

    localparam int CNT_W = $clog2(MAX_HOLD);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_PORTS-1:0] gnt_q, gnt_d;
    logic                 valid_q, valid_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic                 to_q, to_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ID_W-1:0]      last_q, last_d;

    logic                 win_found;
    logic [ID_W-1:0]      win_id;
    logic [ID_W-1:0]      idx;
    logic                 at_limit;
    logic                 owner_req;
    logic                 rel;

    // Round-robin search: walk from last_q+1 upward with wrap; the
    // first requesting port wins.
    always_comb begin
        idx       = last_q;
        win_found = 1'b0;
        win_id    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = (idx == ID_W'(NUM_PORTS - 1)) ? '0 : idx + 1'b1;
            if (!win_found && req_i[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
    end

    // Release conditions for the current owner.
    always_comb begin
        at_limit  = (cnt_q == CNT_W'(MAX_HOLD - 1));
        owner_req = req_i[id_q];
        rel       = done_i | ~owner_req | at_limit;
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
            last_q  <= ID_W'(NUM_PORTS - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    // Next-state logic. A release always passes through IDLE, giving
    // the mandatory one-cycle turnaround between tenures.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_found) state_d = GRANT;
            GRANT:   if (rel)       state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values.
    always_comb begin
        gnt_d   = '0;
        valid_d = 1'b0;
        id_d    = '0;
        to_d    = 1'b0;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    gnt_d[win_id] = 1'b1;
                    valid_d       = 1'b1;
                    id_d          = win_id;
                    cnt_d         = '0;
                    last_d        = win_id;
                end
            end
            GRANT: begin
                if (rel) begin
                    // Timeout only when the limit is the sole cause.
                    to_d  = at_limit & ~done_i & owner_req;
                    cnt_d = '0;
                end else begin
                    gnt_d   = gnt_q;
                    valid_d = 1'b1;
                    id_d    = id_q;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    assign gnt_o       = gnt_q;
    assign gnt_valid_o = valid_q;
    assign gnt_id_o    = id_q;
    assign timeout_o   = to_q;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// tb_rr_lock_arbiter: directed + random stimulus against a tenure-based
// reference model of the round-robin locking arbiter.
module tb_rr_lock_arbiter;

    localparam int NP = 5;
    localparam int MH = 16;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NP-1:0] req;
    logic          done;
    logic [NP-1:0] gnt;
    logic          gnt_valid;
    logic [IW-1:0] gnt_id;
    logic          timeout;

    int checks   = 0;
    int failures = 0;

    // Model: owner index (-1 = none), cycles the grant has been visible,
    // last winner, expected timeout pulse.
    int   m_own;
    int   m_held;
    int   m_last;
    logic m_to;

    rr_lock_arbiter #(
        .NUM_PORTS(NP),
        .MAX_HOLD (MH)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_i      (req),
        .done_i     (done),
        .gnt_o      (gnt),
        .gnt_valid_o(gnt_valid),
        .gnt_id_o   (gnt_id),
        .timeout_o  (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_own  = -1;
        m_held = 0;
        m_last = NP - 1;
        m_to   = 1'b0;
    endtask

    task automatic m_edge();
        bit found;
        int p;
        if (!rst_n) begin
            m_reset();
        end else begin
            m_to = 1'b0;
            if (m_own < 0) begin
                found = 0;
                for (int k = 1; k <= NP; k++) begin
                    p = (m_last + k) % NP;
                    if (!found && req[p]) begin
                        found  = 1;
                        m_own  = p;
                        m_last = p;
                        m_held = 1;
                    end
                end
            end else if (done || !req[m_own] || m_held == MH) begin
                m_to   = (m_held == MH) && !done && req[m_own];
                m_own  = -1;
                m_held = 0;
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic check_out(input string tag);
        logic [NP-1:0] eg;
        int            eid;
        eg  = (m_own < 0) ? '0 : (NP'(1) << m_own);
        eid = (m_own < 0) ? 0 : m_own;
        chk({tag, "_gnt"}, 32'(gnt), 32'(eg));
        chk({tag, "_vld"}, 32'(gnt_valid), 32'(m_own >= 0));
        chk({tag, "_id"}, 32'(gnt_id), eid);
        chk({tag, "_to"}, 32'(timeout), 32'(m_to));
        chk({tag, "_1hot"}, 32'($countones(gnt) <= 1), 1);
    endtask

    task automatic step();
        @(posedge clk);
        m_edge();
        #1;
        check_out("mdl");
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        m_reset();

        // Reset holds everything low even with all ports requesting.
        req = 5'b11111;
        #2;
        check_out("rst0");
        repeat (3) step();
        chk("rst_hold", 32'(gnt), 0);
        rst_n = 1'b1;
        step();
        chk("first_gnt", 32'(gnt), 32'h01);
        chk("first_id", 32'(gnt_id), 0);

        // Rotation with done in the 2nd cycle of each grant.
        for (int g = 0; g < 6; g++) begin
            chk("rr_seq", 32'(gnt), 32'(1) << (g % NP));
            done = 1'b0;
            step();
            done = 1'b1;
            step();
            chk("rr_gap", 32'(gnt), 0);
            done = 1'b0;
            step();
        end
        req = '0;
        step();
        step();

        // Full tenure on a lone requester ends in a timeout.
        req = 5'b00100;
        step();
        for (int i = 1; i <= 15; i++) begin
            step();
            chk("hold16", 32'(gnt), 32'h04);
        end
        step();
        chk("to_pulse", 32'(timeout), 1);
        chk("to_drop", 32'(gnt), 0);
        step();
        chk("regrant", 32'(gnt), 32'h04);
        chk("to_once", 32'(timeout), 0);

        // done coinciding with the limit: no timeout.
        repeat (15) step();
        done = 1'b1;
        step();
        done = 1'b0;
        chk("done_lim_to", 32'(timeout), 0);
        chk("done_lim_gnt", 32'(gnt), 0);

        // Owner drops its request; search wraps from 4 to 0.
        req = 5'b01001;
        step();
        chk("p3_gnt", 32'(gnt), 32'h08);
        repeat (3) step();
        req = 5'b00001;
        step();
        chk("drop_rel", 32'(gnt), 0);
        step();
        chk("wrap", 32'(gnt), 32'h01);

        // Asynchronous reset mid-grant.
        #3;
        rst_n = 1'b0;
        #1;
        m_reset();
        check_out("arst");
        chk("arst_gnt", 32'(gnt), 0);
        step();
        req   = 5'b10010;
        rst_n = 1'b1;
        step();
        chk("post_rst", 32'(gnt), 32'h02);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            req  = req ^ NP'($urandom & $urandom & $urandom);
            done = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 499) == 0) begin
                #3;
                rst_n = 1'b0;
                #1;
                m_reset();
                check_out("rnd_arst");
                step();
                rst_n = 1'b1;
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_lock_arbiter.md
RR_LOCK_ARBITER -- requirements
Module: rr_lock_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_PORTS, default 5, number of requesters (legal 2..32).
REQ-002 The block SHALL have parameter MAX_HOLD, default 16, maximum grant tenure in cycles (legal 2..1024).
REQ-003 The block SHALL have localparam ID_W = max(1, clog2(NUM_PORTS)), grant index width.
REQ-004 The block SHALL have port clk_i  input  1  single clock, all state updates on its rising edge.
REQ-005 The block SHALL have port rst_ni  input  1  reset, asynchronous and active-low.
REQ-006 The block SHALL have port req_i  input  NUM_PORTS  request per port, level, held until served.
REQ-007 The block SHALL have port done_i  input  1  owner finished with resource, one-cycle pulse, ignored when no grant.
REQ-008 The block SHALL have port gnt_o  output  NUM_PORTS  registered grant, one-hot or zero.
REQ-009 The block SHALL have port gnt_valid_o  output  1  high exactly when gnt_o is non-zero.
REQ-010 The block SHALL have port gnt_id_o  output  ID_W  binary index of granted port, 0 when no grant.
REQ-011 The block SHALL have port timeout_o  output  1  one-cycle pulse when a grant is forcibly revoked.

Function
REQ-012 The block SHALL implement a two-state FSM, IDLE and GRANT; all outputs SHALL be registered.
REQ-013 In IDLE with req_i != 0 at a rising edge, the block SHALL enter GRANT and assert gnt_o for the winner after that edge (1-cycle request-to-grant latency).
REQ-014 Arbitration SHALL be round-robin: search starts at index last_id+1 mod NUM_PORTS, ascending with wrap; the first requesting port wins.
REQ-015 last_id SHALL update to the winner's index on every new grant and SHALL not change otherwise.
REQ-016 In IDLE with req_i == 0, gnt_o SHALL remain 0 and state SHALL remain IDLE.
REQ-017 In GRANT, the grant SHALL be held locked; requests from other ports SHALL not preempt it.
REQ-018 A hold counter SHALL clear to 0 on grant and increment on each GRANT edge without a release.
REQ-019 Release SHALL occur at the edge where any of the following holds: done_i=1; req_i[gnt_id] drops to 0; the hold counter equals MAX_HOLD-1.
REQ-020 On release, gnt_o, gnt_valid_o and gnt_id_o SHALL clear after that edge, and the FSM SHALL return to IDLE for at least one cycle (mandatory turnaround, no back-to-back grants).
REQ-021 timeout_o SHALL pulse for one cycle, aligned with the gnt_o drop, only when the release is caused solely by the counter limit.
REQ-022 When done_i or a request drop coincides with the counter limit, the block SHALL release without a timeout_o pulse.
REQ-023 A grant SHALL therefore last between 1 and MAX_HOLD cycles inclusive.
REQ-024 done_i in IDLE SHALL have no effect.
REQ-025 gnt_o SHALL never have more than one bit set.

Reset
REQ-026 While rst_ni=0, gnt_o=0, gnt_valid_o=0, gnt_id_o=0 and timeout_o=0 SHALL hold immediately, independent of clk_i; FSM=IDLE, counter=0, last_id=NUM_PORTS-1 (port 0 highest first priority).
REQ-027 Reset asserted mid-grant SHALL abort the tenure with no timeout_o pulse.
REQ-028 The first grant after reset release SHALL occur no earlier than one edge after rst_ni rises.

Verification (NUM_PORTS=5, MAX_HOLD=16)
REQ-029 The bench SHALL cover: rst_ni=0 with req_i=11111 -> gnt_o=00000 throughout; rst_ni=1 -> gnt_o=00001, gnt_id_o=0 one edge later.
REQ-030 The bench SHALL cover: req_i=11111 constant, done_i pulsed in the 2nd cycle of each grant -> gnt_o sequence 00001,00010,00100,01000,10000,00001, each separated by one zero cycle.
REQ-031 The bench SHALL cover: req_i=00100 held, done_i=0 -> gnt_o=00100 for exactly 16 cycles, timeout_o=1 in the first zero cycle, then re-grant 00100 after one idle cycle.
REQ-032 The bench SHALL cover: done_i=1 on the 16th grant cycle -> release with timeout_o=0.
REQ-033 The bench SHALL cover: port 3 granted, req_i[3] drops on cycle 4 -> gnt_o=00000 after that edge; pending req_i=00001 granted next (search from 4 wraps to 0).
REQ-034 The bench SHALL cover: rst_ni pulled low mid-grant between clock edges -> all outputs 0 immediately; after release with req_i=10010 -> gnt_o=00010.
